// File: rtl/fp16_pkg.sv
// Shared FP16 definitions for the add/sub datapath and its controllers.
package fp16_pkg;
  localparam int EXP_W      = 5;
  localparam int MAN_W      = 10;
  localparam int FP16_W     = 1 + EXP_W + MAN_W;
  localparam int ADDSUB_LAT = 3;

  localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;
  localparam logic [FP16_W-1:0] FP16_ONE  = 16'h3C00;
  localparam logic [FP16_W-1:0] FP16_TWO  = 16'h4000;

  typedef struct packed {
    logic [FP16_W-1:0] a;
    logic [FP16_W-1:0] b;
    logic              sub;
  } fp16_op_t;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; rd_data reads as zero while empty.
module sync_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_wr, do_rd;

  // Pointers wrap explicitly so non power-of-two depths work.
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_rd   = rd_en && (count != '0);
  assign do_wr   = wr_en && ((count != CW'(DEPTH)) || do_rd);
  assign rd_data = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= inc(wr_ptr);
      if (do_rd) rd_ptr <= inc(rd_ptr);
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/fp16_addsub_sequencer.sv
// Issues tagged FP16 add/sub ops into a fixed-latency pipeline and collects
// results in order, using credits so a completing result always has a slot.
module fp16_addsub_sequencer
  import fp16_pkg::*;
#(
  parameter  int LAT   = ADDSUB_LAT,
  parameter  int DEPTH = 8,
  parameter  int TAG_W = 4,
  localparam int IW    = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [15:0]      cmd_a,
  input  logic [15:0]      cmd_b,
  input  logic             cmd_sub,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [15:0]      fpu_a,
  output logic [15:0]      fpu_b,
  output logic             fpu_select,
  output logic             fpu_start,
  input  logic [15:0]      fpu_out,
  input  logic             fpu_done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic [IW-1:0]    inflight,
  output logic             proto_err
);
  localparam int BW = $clog2(LAT + 1);
  localparam int RW = FP16_W + TAG_W;

  logic [BW-1:0]             blank;
  fp16_op_t                  iss;
  logic [TAG_W-1:0]          iss_tag;
  logic [LAT-1:0]            vld_pipe;
  logic [LAT-1:0][TAG_W-1:0] tag_pipe;
  logic                      live, accept, pop, push, lost, spurious;
  logic [IW-1:0]             infl_nxt;
  logic [RW-1:0]             fifo_rd;
  logic [IW-1:0]             fifo_cnt;

  // The pipeline has no reset, so Done is not trusted until the blank window ends.
  assign live      = (blank == '0);
  assign cmd_ready = live && (inflight < IW'(DEPTH));
  assign accept    = cmd_valid && cmd_ready;
  assign push      = live && vld_pipe[LAT-1] && fpu_done;
  assign lost      = live && vld_pipe[LAT-1] && !fpu_done;
  assign spurious  = live && fpu_done && !vld_pipe[LAT-1];
  assign res_valid = (fifo_cnt != '0);
  assign pop       = res_valid && res_ready;

  assign fpu_a      = iss.a;
  assign fpu_b      = iss.b;
  assign fpu_select = iss.sub;
  assign {res_data, res_tag} = fifo_rd;

  always_comb begin
    infl_nxt = inflight;
    if (accept) infl_nxt = infl_nxt + IW'(1);
    if (pop)    infl_nxt = infl_nxt - IW'(1);
    if (lost)   infl_nxt = infl_nxt - IW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      blank     <= BW'(LAT);
      fpu_start <= 1'b0;
      iss       <= '{a: FP16_ZERO, b: FP16_ZERO, sub: 1'b0};
      iss_tag   <= '0;
      vld_pipe  <= '0;
      tag_pipe  <= '0;
      inflight  <= '0;
      proto_err <= 1'b0;
    end else begin
      if (!live) blank <= blank - BW'(1);
      fpu_start <= accept;
      if (accept) begin
        iss     <= '{a: cmd_a, b: cmd_b, sub: cmd_sub};
        iss_tag <= cmd_tag;
      end
      // Tag pipe tracks Start so its last stage lines up with Done.
      vld_pipe[0] <= fpu_start;
      tag_pipe[0] <= iss_tag;
      for (int i = 1; i < LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
      inflight <= infl_nxt;
      if (spurious || lost) proto_err <= 1'b1;
    end
  end

  sync_fifo #(.W(RW), .DEPTH(DEPTH)) u_res_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .wr_en   (push),
    .wr_data ({fpu_out, tag_pipe[LAT-1]}),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .count   (fifo_cnt)
  );
endmodule

// File: tb/tb_fp16_addsub_sequencer.sv
// Directed bench for fp16_addsub_sequencer with a no-reset LAT=3 pipeline model.
module tb_fp16_addsub_sequencer;
  import fp16_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_sub = 1'b0;
  logic [15:0] cmd_a = '0, cmd_b = '0;
  logic [3:0]  cmd_tag = '0;
  logic [15:0] fpu_a, fpu_b, fpu_out;
  logic        fpu_select, fpu_start, fpu_done;
  logic        res_valid, res_ready = 1'b0;
  logic [15:0] res_data;
  logic [3:0]  res_tag;
  logic [3:0]  inflight;
  logic        proto_err;

  logic        inj_done = 1'b0, kill_done = 1'b0, mon_en = 1'b0;
  int          n_chk = 0, n_pass = 0;
  logic [19:0] exp_q[$];

  always #5 CLK = ~CLK;

  fp16_addsub_sequencer #(.LAT(3), .DEPTH(8), .TAG_W(4)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_sub(cmd_sub), .cmd_tag(cmd_tag),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_select(fpu_select), .fpu_start(fpu_start),
    .fpu_out(fpu_out), .fpu_done(fpu_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_tag(res_tag),
    .inflight(inflight), .proto_err(proto_err)
  );

  // Known FP16 results for the directed cases; other operands give a distinct pattern.
  function automatic logic [15:0] ref_out(input logic [15:0] a, input logic [15:0] b, input logic s);
    if (a == FP16_ONE && b == FP16_TWO && !s) return 16'h4200;
    if (a == FP16_TWO && b == FP16_ONE && s)  return FP16_ONE;
    if (a == FP16_ONE && b == FP16_ONE && s)  return FP16_ZERO;
    return a ^ b ^ {15'd0, s};
  endfunction

  // Pipeline model: never reset, so in-flight ops produce stale Done after a reset.
  logic [2:0]       pm_v = '0;
  logic [2:0][15:0] pm_d = '0;
  always @(posedge CLK) begin
    pm_v <= {pm_v[1:0], fpu_start};
    pm_d <= {pm_d[1:0], ref_out(fpu_a, fpu_b, fpu_select)};
  end
  assign fpu_done = (pm_v[2] | inj_done) & ~kill_done;
  assign fpu_out  = pm_d[2];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  always @(negedge CLK) begin
    if (mon_en && !RST && res_valid && res_ready) begin
      if (exp_q.size() == 0) chk("unexpected_res", 1, 0);
      else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        chk("res_data", res_data, e[19:4]);
        chk("res_tag", res_tag, e[3:0]);
      end
    end
  end

  // Reset, then watch the blank window while a stale Done is injected.
  task automatic do_reset(input int n);
    RST = 1'b1;
    repeat (n) step();
    RST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      inj_done = (k == 2);
      chk("blank_rdy", cmd_ready, 0);
      chk("blank_rv", res_valid, 0);
      chk("blank_perr", proto_err, 0);
      step();
    end
    inj_done = 1'b0;
    chk("post_blank_rdy", cmd_ready, 1);
    chk("post_blank_perr", proto_err, 0);
    chk("post_blank_infl", inflight, 0);
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s,
                      input logic [3:0] tag, input logic [15:0] exp, input logic track);
    int k;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_sub = s; cmd_tag = tag;
    for (k = 0; k < 50 && !cmd_ready; k++) step();
    if (!cmd_ready) chk("send_timeout", 0, 1);
    if (track) exp_q.push_back({exp, tag});
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) step();
    chk("drain_empty", exp_q.size(), 0);
    step();
    chk("drain_infl", inflight, 0);
  endtask

  initial begin
    int idx;
    logic go;
    step(); step();
    chk("rst_start", fpu_start, 0);
    chk("rst_ab", {fpu_a, fpu_b}, 0);
    chk("rst_sel", fpu_select, 0);
    chk("rst_rv", res_valid, 0);
    chk("rst_data", {res_data, res_tag}, 0);
    chk("rst_rdy", cmd_ready, 0);
    chk("rst_infl", inflight, 0);
    chk("rst_perr", proto_err, 0);
    do_reset(1);

    // Single add with explicit cycle-by-cycle timing
    cmd_valid = 1'b1; cmd_a = FP16_ONE; cmd_b = FP16_TWO; cmd_sub = 1'b0; cmd_tag = 4'd5;
    chk("add_rdy", cmd_ready, 1);
    step();                                   // cycle 1
    cmd_valid = 1'b0;
    chk("add_start1", fpu_start, 1);
    chk("add_ops", {fpu_a, fpu_b}, {FP16_ONE, FP16_TWO});
    chk("add_sel", fpu_select, 0);
    chk("add_infl1", inflight, 1);
    step();                                   // cycle 2
    chk("add_start2", fpu_start, 0);
    chk("add_ops_hold", fpu_a, FP16_ONE);
    step(); step();                           // cycle 4
    chk("add_rv4", res_valid, 0);
    step();                                   // cycle 5
    chk("add_rv5", res_valid, 1);
    chk("add_data", res_data, 16'h4200);
    chk("add_tag", res_tag, 5);
    chk("add_infl5", inflight, 1);
    step();
    chk("add_hold_data", res_data, 16'h4200);
    res_ready = 1'b1;
    step();
    chk("add_rv_pop", res_valid, 0);
    chk("add_infl_pop", inflight, 0);

    // Subtracts through the scoreboard
    mon_en = 1'b1;
    send(FP16_TWO, FP16_ONE, 1'b1, 4'd2, FP16_ONE, 1'b1);
    send(FP16_ONE, FP16_ONE, 1'b1, 4'd7, FP16_ZERO, 1'b1);
    drain();

    // Streaming: 16 back-to-back, one result per cycle from cycle 5
    for (int c = 0; c < 22; c++) begin
      if (c < 16) begin
        cmd_valid = 1'b1; cmd_a = 16'(c * 256); cmd_b = 16'h00A5; cmd_sub = 1'b0;
        cmd_tag = 4'(c);
        chk("stream_rdy", cmd_ready, 1);
        exp_q.push_back({16'(c * 256) ^ 16'h00A5, 4'(c)});
      end else cmd_valid = 1'b0;
      if (c >= 5 && c <= 20) chk("stream_rv", res_valid, 1);
      if (c == 21) chk("stream_rv_end", res_valid, 0);
      step();
    end
    drain();

    // Backpressure: credits stop acceptance at DEPTH
    res_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 80; c++) begin
      if (c == 20) begin
        chk("bp_accepted", idx, 8);
        chk("bp_infl", inflight, 8);
        chk("bp_rdy", cmd_ready, 0);
        chk("bp_head", res_data, 16'h2000 ^ 16'h0101);
        res_ready = 1'b1;
      end
      if (c > 20 && idx == 10 && exp_q.size() == 0) break;
      cmd_valid = (idx < 10);
      cmd_a = 16'h2000 + 16'(idx); cmd_b = 16'h0101; cmd_sub = idx[0]; cmd_tag = 4'(idx);
      go = cmd_valid && cmd_ready;
      if (go) exp_q.push_back({(16'h2000 + 16'(idx)) ^ 16'h0101 ^ {15'd0, idx[0]}, 4'(idx)});
      step();
      if (go) idx++;
    end
    cmd_valid = 1'b0;
    chk("bp_total", idx, 10);
    drain();

    // Reset with two ops in flight; their Done pulses land in the blank window
    send(16'h1111, 16'h0001, 1'b0, 4'd1, 16'h0, 1'b0);
    send(16'h2222, 16'h0002, 1'b0, 4'd2, 16'h0, 1'b0);
    step();
    exp_q.delete();
    do_reset(1);
    chk("rst_mid_rv", res_valid, 0);
    repeat (3) step();
    chk("rst_mid_rv_late", res_valid, 0);

    // Spurious Done with an empty tag pipe
    inj_done = 1'b1;
    step();
    inj_done = 1'b0;
    chk("perr_set", proto_err, 1);
    chk("perr_no_push", res_valid, 0);
    repeat (4) step();
    chk("perr_sticky", proto_err, 1);
    chk("perr_infl", inflight, 0);
    do_reset(1);

    // Missing Done: entry lost, credit returned
    kill_done = 1'b1;
    send(16'h3333, 16'h0003, 1'b0, 4'd3, 16'h0, 1'b0);
    chk("lost_infl_busy", inflight, 1);
    repeat (6) step();
    chk("lost_infl", inflight, 0);
    chk("lost_perr", proto_err, 1);
    chk("lost_rv", res_valid, 0);
    kill_done = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/fp16_addsub_sequencer.md
Name: fp16_addsub_sequencer

Overview:
Initiator-side controller for the team's FP16 add/sub pipeline, which has a fixed Start->Done latency, no reset, and an Out that is valid with Done.
- Front end: accepts tagged operand commands on a valid/ready interface.
- Issue: drives Start/operands to the pipeline, at most one per cycle.
- Tracking: follows in-flight ops with a tag shift register aligned to the pipeline latency.
- Collection: captures each result into an in-order result FIFO with backpressure.
- Credit flow control guarantees no result is ever dropped.

Parameters:
LAT, 3, Start->Done latency of the add/sub pipeline in cycles (>=1)
DEPTH, 8, result FIFO entries and credit limit (>=2; >=LAT+2 gives full throughput)
TAG_W, 4, command tag width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_a  in  16  FP16 operand A
cmd_b  in  16  FP16 operand B
cmd_sub  in  1  1 = A-B, 0 = A+B
cmd_tag  in  TAG_W  user tag returned with result
fpu_a  out  16  to pipeline Ain
fpu_b  out  16  to pipeline Bin
fpu_select  out  1  to pipeline Select
fpu_start  out  1  to pipeline Start, one-cycle pulse per op
fpu_out  in  16  pipeline Out
fpu_done  in  1  pipeline Done
res_valid  out  1  result available
res_ready  in  1  result consumed when res_valid && res_ready
res_data  out  16  FP16 result
res_tag  out  TAG_W  tag of res_data
inflight  out  clog2(DEPTH+1)  credit occupancy (accepted, not yet popped)
proto_err  out  1  sticky protocol error

Behaviour:
- Reset values (RST high at an edge): fpu_start=0, fpu_a=fpu_b=0, fpu_select=0, res_valid=0, res_data=0, res_tag=0, cmd_ready=0, inflight=0, proto_err=0.
- Reset clears the tag pipe, FIFO and credits; reset mid-operation discards all in-flight and queued results.
- Post-reset blanking: the pipeline has no reset and may emit stale Done pulses. For LAT cycles after RST deasserts, the blank counter is nonzero:
  - cmd_ready=0;
  - fpu_done is ignored: no capture, no proto_err.
- Issue register:
  - On accept in cycle N, fpu_a/fpu_b/fpu_select are registered from cmd_a/cmd_b/cmd_sub, and fpu_start=1 in cycle N+1.
  - With no accept, fpu_start=0 and the operand registers hold their last value.
- Tag pipe: LAT stages of {valid, tag}.
  - Stage 0 loads {fpu_start, issued tag} each cycle.
  - The last stage aligns with fpu_done (cycle N+1+LAT).
- Capture: when the last stage is valid and fpu_done=1, push {fpu_out, tag} into the FIFO.
- proto_err is set, and stays set until RST, when either:
  - fpu_done=1 while the last stage is invalid (no push occurs); or
  - the last stage is valid while fpu_done=0 (the entry is lost and its credit is returned).
- Credits:
  - inflight +1 on accept, -1 on pop, -1 on a lost entry. Simultaneous events net out.
  - cmd_ready = (blank==0) && (inflight < DEPTH), from registered state only; no combinational path from cmd_valid.
  - Credits cover the issue register, the pipe and the FIFO, so a push never meets a full FIFO.
- Result FIFO:
  - Registered write, first-word-fall-through read.
  - res_valid rises the cycle after the push into an empty FIFO.
  - Accept-to-res_valid latency = LAT+2 cycles (5 by default).
  - Simultaneous push and pop are allowed at any occupancy. Pointers wrap modulo DEPTH.
  - res_data/res_tag hold stable while res_valid && !res_ready.
- Ordering: results leave in strict acceptance order. Throughput is one op per cycle when res_ready=1 and DEPTH >= LAT+2.
- No FP arithmetic is done here; fpu_out passes through bit-exact.

Decomposition:
- Shared package fp16_pkg holds:
  - FP16_W=16, EXP_W=5, MAN_W=10;
  - ADDSUB_LAT=3, the default for LAT;
  - constants FP16_ZERO=16'h0000, FP16_ONE=16'h3C00, FP16_TWO=16'h4000.
- One sub-module, sync_fifo: parameterized width/depth, synchronous active-high reset, FWFT, count output. The result FIFO is an instance of sync_fifo with width 16+TAG_W.

Test Plan:
- Single add: cmd {a=0x3C00, b=0x4000, sub=0, tag=5} accepted at cycle 0, paired with the real pipeline -> fpu_start in cycle 1 only; res_valid in cycle 5 with res_data=0x4200, res_tag=5; inflight returns to 0 after pop.
- Subtract: {a=0x4000, b=0x3C00, sub=1, tag=2} -> res_data=0x3C00. Equal-operand subtract {0x3C00, 0x3C00, sub=1} -> res_data=0x0000.
- Streaming: 16 back-to-back commands, tags 0..15, res_ready=1 -> cmd_ready never drops after blanking; one result per cycle from cycle 5; tags in order 0..15.
- Backpressure: res_ready=0, 10 commands offered -> exactly 8 accepted, cmd_ready=0 with inflight=8; after res_ready=1, all 8 results drain in order, then the remaining 2 are accepted.
- Reset mid-operation: 2 ops in flight, RST high 1 cycle, stale fpu_done pulses during blanking -> no res_valid, proto_err=0, cmd_ready=0 for 3 cycles then 1.
- Protocol error: inject fpu_done=1 with the tag pipe empty after blanking -> proto_err=1, no push, proto_err holds until RST.
